ahb_lite_mem_slave_p: RTL and testbench

- Parametrised AHB-Lite memory slave: the next-generation target behind the master BFM tasks (single read/write, 4/8/16-beat bursts with BUSY).
- Configurable data width, depth and wait states; a low read-only (ROM) region.
- Byte/halfword/word lanes via HSIZE; write-to-read forwarding; burst-address checking; two-cycle ERROR response.
- Sits as the single slave on the bus, driving HREADY directly.

---
 rtl/ahb_lite_mem_slave_p_if.sv | 30 +++
 rtl/ahb_lite_mem_slave_p.sv | 194 +++++++++++++++++++
 tb/tb_ahb_lite_mem_slave_p.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_lite_mem_slave_p_if.sv
// AHB-Lite bus bundle between a single master and the memory slave.
//   master modport : drives HSEL, HADDR, HWRITE, HSIZE, HBURST, HTRANS, HWDATA;
//                    receives HRDATA, HREADY, HRESP
//   slave modport  : the mirror image
// HCLK and HRESETn are kept outside the bundle as plain ports.
interface ahb_lite_mem_slave_p_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
);
  logic                     HSEL;
  logic [ADDRESS_WIDTH-1:0] HADDR;
  logic                     HWRITE;
  logic [2:0]               HSIZE;
  logic [2:0]               HBURST;
  logic [1:0]               HTRANS;
  logic [DATA_WIDTH-1:0]    HWDATA;
  logic [DATA_WIDTH-1:0]    HRDATA;
  logic                     HREADY;
  logic                     HRESP;

  modport master (
    output HSEL, HADDR, HWRITE, HSIZE, HBURST, HTRANS, HWDATA,
    input  HRDATA, HREADY, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HWRITE, HSIZE, HBURST, HTRANS, HWDATA,
    output HRDATA, HREADY, HRESP
  );
endinterface

// File: rtl/ahb_lite_mem_slave_p.sv
// AHB-Lite memory slave, the only slave on the bus (drives HREADY directly).
//   HCLK    : bus clock, everything on the rising edge
//   HRESETn : asynchronous active-low reset (memory contents survive it)
//   bus     : ahb_lite_mem_slave_p_if.slave -- address/control/write data in,
//             HRDATA/HREADY/HRESP out
// Word-addressed RAM of MEM_DEPTH x DATA_WIDTH with a read-only low region,
// byte/halfword/word lanes, WAIT_STATES stall cycles per OKAY data phase,
// burst address checking and the two-cycle ERROR response.
module ahb_lite_mem_slave_p #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int MEM_DEPTH     = 256,
  parameter int WAIT_STATES   = 0,
  parameter int ROM_WORDS     = 16
) (
  input logic                   HCLK,
  input logic                   HRESETn,
  ahb_lite_mem_slave_p_if.slave bus
);
  localparam int NB   = DATA_WIDTH / 8;
  localparam int BS   = $clog2(NB);
  localparam int IDXW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DONE, S_ERR1, S_ERR2} state_t;

  // Byte lanes touched by a transfer of 2**size bytes at lane offset off.
  function automatic logic [NB-1:0] lane_mask(input logic [2:0] size, input logic [BS-1:0] off);
    logic [NB-1:0] m;
    int            nbytes;
    nbytes = 1 << size;
    for (int b = 0; b < NB; b++) begin
      m[b] = (b >= int'(off)) && (b < int'(off) + nbytes);
    end
    return m;
  endfunction

  // Replace the selected lanes of old_w with those of new_w.
  function automatic logic [DATA_WIDTH-1:0] merge_lanes(input logic [DATA_WIDTH-1:0] old_w,
                                                         input logic [DATA_WIDTH-1:0] new_w,
                                                         input logic [NB-1:0]         mask);
    logic [DATA_WIDTH-1:0] r;
    for (int b = 0; b < NB; b++) begin
      r[8*b +: 8] = mask[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
    end
    return r;
  endfunction

  // Address the next SEQ beat must carry. WRAP bursts (even non-zero HBURST)
  // stay inside a beats*size aligned block; everything else increments.
  function automatic logic [ADDRESS_WIDTH-1:0] burst_next(input logic [ADDRESS_WIDTH-1:0] a,
                                                           input logic [2:0]               size,
                                                           input logic [2:0]               burst);
    logic [ADDRESS_WIDTH-1:0] one, step, inc, blk;
    one  = ADDRESS_WIDTH'(1);
    step = one << size;
    inc  = a + step;
    case (burst)
      3'd2:    blk = step << 2;
      3'd4:    blk = step << 3;
      3'd6:    blk = step << 4;
      default: blk = '0;
    endcase
    if (blk == '0) return inc;
    return (a & ~(blk - one)) | (inc & (blk - one));
  endfunction

  state_t                   state, state_nxt;
  logic [3:0]               cnt, cnt_nxt;
  logic                     hready, hresp;
  logic [DATA_WIDTH-1:0]    rdata;

  logic                     accept, is_seq, err_p0;
  logic [ADDRESS_WIDTH-1:0] widx_p0;
  logic [7:0]               amask;

  logic                     trk_vld;
  logic [ADDRESS_WIDTH-1:0] trk_next;

  logic                     write_p1;
  logic [IDXW-1:0]          idx_p1;
  logic [BS-1:0]            off_p1;
  logic [2:0]               size_p1;

  logic                     wr_en;
  logic [NB-1:0]            wr_mask;
  logic                     rd_from_bus, rd_from_p1, rd_load;
  logic [IDXW-1:0]          rd_idx;
  logic [DATA_WIDTH-1:0]    rd_word;

  logic [DATA_WIDTH-1:0]    mem [MEM_DEPTH];

  assign hready = (state == S_IDLE) || (state == S_DONE) || (state == S_ERR2);
  assign hresp  = (state == S_ERR1) || (state == S_ERR2);

  assign bus.HREADY = hready;
  assign bus.HRESP  = hresp;
  assign bus.HRDATA = rdata;

  // Address phase (p0): decode and error checks on the sampled request
  always_comb begin
    accept  = hready && bus.HSEL && bus.HTRANS[1];
    is_seq  = (bus.HTRANS == 2'b11);
    widx_p0 = bus.HADDR >> BS;
    amask   = (8'd1 << bus.HSIZE) - 8'd1;
    err_p0  = (widx_p0 >= ADDRESS_WIDTH'(MEM_DEPTH))
           || (bus.HWRITE && (widx_p0 < ADDRESS_WIDTH'(ROM_WORDS)))
           || (bus.HSIZE > 3'(BS))
           || ((bus.HADDR[7:0] & amask) != 8'd0)
           || (is_seq && (!trk_vld || (bus.HADDR != trk_next)));
  end

  // Next state: a new address phase can only be taken while HREADY is high,
  // i.e. from IDLE, DONE or ERR2; the stall states run to completion.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_WAIT: begin
        if (cnt == 4'd1) state_nxt = S_DONE;
        else             cnt_nxt   = cnt - 4'd1;
      end
      S_ERR1: state_nxt = S_ERR2;
      default: begin
        if (accept) begin
          if (err_p0) begin
            state_nxt = S_ERR1;
          end else if (WAIT_STATES == 0) begin
            state_nxt = S_DONE;
          end else begin
            state_nxt = S_WAIT;
            cnt_nxt   = 4'(WAIT_STATES);
          end
        end else begin
          state_nxt = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Data phase (p1): write commit and read fetch
  always_comb begin
    wr_en       = (state == S_DONE) && write_p1;
    wr_mask     = lane_mask(size_p1, off_p1);
    // Zero-wait reads fetch straight off the address bus; stalled reads
    // fetch from the held data-phase index on the last WAIT cycle.
    rd_from_bus = accept && !err_p0 && !bus.HWRITE && (WAIT_STATES == 0);
    rd_from_p1  = (state == S_WAIT) && (cnt == 4'd1) && !write_p1;
    rd_load     = rd_from_bus || rd_from_p1;
    rd_idx      = rd_from_bus ? widx_p0[IDXW-1:0] : idx_p1;
    // The write finishing this cycle lands in the array only at the edge,
    // so a read of the same word takes its new lanes from HWDATA.
    if (wr_en && (rd_idx == idx_p1)) rd_word = merge_lanes(mem[rd_idx], bus.HWDATA, wr_mask);
    else                             rd_word = mem[rd_idx];
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      write_p1 <= 1'b0;
      trk_vld  <= 1'b0;
      rdata    <= '0;
    end else begin
      if (accept) begin
        write_p1 <= bus.HWRITE;
        if (!err_p0) trk_vld <= (bus.HBURST != 3'd0);
      end
      if (rd_load)                              rdata <= rd_word;
      else if (accept && err_p0 && !bus.HWRITE) rdata <= '0;
    end
  end

  always_ff @(posedge HCLK) begin
    if (accept) begin
      idx_p1  <= widx_p0[IDXW-1:0];
      off_p1  <= bus.HADDR[BS-1:0];
      size_p1 <= bus.HSIZE;
      if (!err_p0) trk_next <= burst_next(bus.HADDR, bus.HSIZE, bus.HBURST);
    end
    if (wr_en) begin
      for (int b = 0; b < NB; b++) begin
        if (wr_mask[b]) mem[idx_p1][8*b +: 8] <= bus.HWDATA[8*b +: 8];
      end
    end
  end
endmodule

// File: tb/tb_ahb_lite_mem_slave_p.sv
module tb_ahb_lite_mem_slave_p;
  localparam logic [1:0] T_IDLE = 2'd0, T_BUSY = 2'd1, T_NSEQ = 2'd2, T_SEQ = 2'd3;

  logic HCLK = 1'b0;
  logic HRESETn;
  always #5 HCLK = ~HCLK;

  logic        m_hsel, m_hwrite;
  logic [31:0] m_haddr, m_hwdata;
  logic [2:0]  m_hsize, m_hburst;
  logic [1:0]  m_htrans;

  ahb_lite_mem_slave_p_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) if0 ();
  ahb_lite_mem_slave_p_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) if2 ();

  assign if0.HSEL   = m_hsel;   assign if2.HSEL   = m_hsel;
  assign if0.HADDR  = m_haddr;  assign if2.HADDR  = m_haddr;
  assign if0.HWRITE = m_hwrite; assign if2.HWRITE = m_hwrite;
  assign if0.HSIZE  = m_hsize;  assign if2.HSIZE  = m_hsize;
  assign if0.HBURST = m_hburst; assign if2.HBURST = m_hburst;
  assign if0.HTRANS = m_htrans; assign if2.HTRANS = m_htrans;
  assign if0.HWDATA = m_hwdata; assign if2.HWDATA = m_hwdata;

  ahb_lite_mem_slave_p #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(256),
                         .WAIT_STATES(0), .ROM_WORDS(16))
    u_dut0 (.HCLK(HCLK), .HRESETn(HRESETn), .bus(if0));

  ahb_lite_mem_slave_p #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(256),
                         .WAIT_STATES(2), .ROM_WORDS(16))
    u_dut2 (.HCLK(HCLK), .HRESETn(HRESETn), .bus(if2));

  // sel picks which slave the master follows and observes (0: WS=0, 1: WS=2)
  logic        sel;
  logic        s_ready, s_resp;
  logic [31:0] s_rdata;
  assign s_ready = sel ? if2.HREADY : if0.HREADY;
  assign s_resp  = sel ? if2.HRESP  : if0.HRESP;
  assign s_rdata = sel ? if2.HRDATA : if0.HRDATA;

  typedef struct {
    logic [1:0]  trans;
    logic        write;
    logic [2:0]  size;
    logic [2:0]  burst;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic        chk_rd;
    logic [31:0] rdata;
  } xfer_t;

  xfer_t       xq[$];   // stimulus still to be issued
  xfer_t       sb[$];   // expected outcomes of accepted transfers
  int          checks = 0;
  int          errors = 0;
  int          ws_cur = 0;
  logic [31:0] last_rdata;

  function automatic void add(input logic [1:0] tr, input logic wr, input logic [2:0] sz,
                              input logic [2:0] bu, input logic [31:0] ad, input logic [31:0] wd,
                              input logic er, input logic ck, input logic [31:0] rd);
    xfer_t x;
    x.trans = tr; x.write = wr; x.size = sz; x.burst = bu; x.addr = ad;
    x.wdata = wd; x.err = er; x.chk_rd = ck; x.rdata = rd;
    xq.push_back(x);
  endfunction

  task automatic drive_idle();
    m_hsel = 1'b0; m_htrans = T_IDLE; m_hwrite = 1'b0; m_haddr = '0;
    m_hsize = 3'd2; m_hburst = 3'd0; m_hwdata = '0;
  endtask

  task automatic settle();
    drive_idle();
    repeat (4) @(posedge HCLK);
    #1;
  endtask

  // Pipelined master: issues xq in order, pushes each accepted active
  // transfer to sb and checks it when its data phase ends.
  task automatic run_queue(input string tag);
    int    ai, budget, nwait, exp_w;
    bit    have_dp;
    logic  r, resp;
    logic [31:0] rd, exp_rd;
    xfer_t dp;
    ai = 0; budget = 0; nwait = 0; have_dp = 0;
    while ((ai < xq.size() || have_dp) && budget < 400) begin
      budget++;
      if (ai < xq.size()) begin
        m_hsel = 1'b1; m_htrans = xq[ai].trans; m_hwrite = xq[ai].write;
        m_haddr = xq[ai].addr; m_hsize = xq[ai].size; m_hburst = xq[ai].burst;
      end else begin
        m_hsel = 1'b0; m_htrans = T_IDLE; m_hwrite = 1'b0;
      end
      if (have_dp) m_hwdata = sb[0].wdata;
      @(negedge HCLK);
      r = s_ready; resp = s_resp; rd = s_rdata;
      if (have_dp) begin
        dp = sb[0];
        if (!r) begin
          nwait++;
          checks++;
          if (resp !== dp.err) begin
            errors++;
            $display("FAIL %s stall_resp @%08h: got %0b want %0b", tag, dp.addr, resp, dp.err);
          end
        end else begin
          checks++;
          if (resp !== dp.err) begin
            errors++;
            $display("FAIL %s resp @%08h: got %0b want %0b", tag, dp.addr, resp, dp.err);
          end
          exp_w = dp.err ? 1 : ws_cur;
          checks++;
          if (nwait != exp_w) begin
            errors++;
            $display("FAIL %s wait_cycles @%08h: got %0d want %0d", tag, dp.addr, nwait, exp_w);
          end
          if (!dp.write && (dp.chk_rd || dp.err)) begin
            exp_rd = dp.err ? 32'h0 : dp.rdata;
            checks++;
            if (rd !== exp_rd) begin
              errors++;
              $display("FAIL %s rdata @%08h: got %08h want %08h", tag, dp.addr, rd, exp_rd);
            end
          end
          if (!dp.write) last_rdata = rd;
          void'(sb.pop_front());
          nwait = 0;
        end
      end else begin
        checks++;
        if (r !== 1'b1 || resp !== 1'b0) begin
          errors++;
          $display("FAIL %s idle_cycle: got ready=%0b resp=%0b want ready=1 resp=0", tag, r, resp);
        end
      end
      @(posedge HCLK);
      if (r) begin
        have_dp = 0;
        if (ai < xq.size()) begin
          if (xq[ai].trans[1]) begin
            sb.push_back(xq[ai]);
            have_dp = 1;
          end
          ai++;
        end
      end
      #1;
    end
    checks++;
    if (budget >= 400) begin
      errors++;
      $display("FAIL %s timeout: got %0d cycles want < 400", tag, budget);
    end
    xq.delete();
    sb.delete();
    settle();
  endtask

  task automatic test_reset();
    sel = 1'b0;
    HRESETn = 1'b0;
    drive_idle();
    repeat (3) @(posedge HCLK);
    @(negedge HCLK);
    checks++; if (if0.HREADY !== 1'b1) begin errors++; $display("FAIL reset hready0: got %0b want 1", if0.HREADY); end
    checks++; if (if0.HRESP !== 1'b0) begin errors++; $display("FAIL reset hresp0: got %0b want 0", if0.HRESP); end
    checks++; if (if0.HRDATA !== 32'h0) begin errors++; $display("FAIL reset hrdata0: got %08h want 0", if0.HRDATA); end
    checks++; if (if2.HREADY !== 1'b1) begin errors++; $display("FAIL reset hready2: got %0b want 1", if2.HREADY); end
    checks++; if (if2.HRESP !== 1'b0) begin errors++; $display("FAIL reset hresp2: got %0b want 0", if2.HRESP); end
    checks++; if (if2.HRDATA !== 32'h0) begin errors++; $display("FAIL reset hrdata2: got %08h want 0", if2.HRDATA); end
    HRESETn = 1'b1;
    settle();
  endtask

  task automatic test_basic();
    sel = 1'b0; ws_cur = 0;
    add(T_NSEQ, 1, 3'd2, 3'd0, 32'h40, 32'hDEADBEEF, 0, 0, 32'h0);
    add(T_NSEQ, 0, 3'd2, 3'd0, 32'h40, 32'h0,        0, 1, 32'hDEADBEEF);
    add(T_IDLE, 0, 3'd2, 3'd0, 32'h0,  32'h0,        0, 0, 32'h0);
    add(T_NSEQ, 0, 3'd2, 3'd0, 32'h40, 32'h0,        0, 1, 32'hDEADBEEF);
    run_queue("basic");
  endtask

  task automatic test_wait_states();
    sel = 1'b1; ws_cur = 2;
    add(T_NSEQ, 1, 3'd2, 3'd0, 32'h44, 32'h5555AAAA, 0, 0, 32'h0);
    add(T_NSEQ, 0, 3'd2, 3'd0, 32'h44, 32'h0,        0, 1, 32'h5555AAAA);
    run_queue("wait2");
  endtask

  task automatic test_forwarding();
    sel = 1'b0; ws_cur = 0;
    add(T_NSEQ, 1, 3'd2, 3'd0, 32'h40, 32'h11223344, 0, 0, 32'h0);
    add(T_NSEQ, 1, 3'd0, 3'd0, 32'h41, 32'h5566AA77, 0, 0, 32'h0);
    add(T_NSEQ, 0, 3'd2, 3'd0, 32'h40, 32'h0,        0, 1, 32'h1122AA44);
    add(T_NSEQ, 1, 3'd1, 3'd0, 32'h42, 32'hBEEF0000, 0, 0, 32'h0);
    add(T_NSEQ, 0, 3'd2, 3'd0, 32'h40, 32'h0,        0, 1, 32'hBEEFAA44);
    run_queue("forward");
  endtask

  task automatic test_errors();
    sel = 1'b0; ws_cur = 0;
    add(T_NSEQ, 1, 3'd2, 3'd0, 32'h08,  32'hCAFEF00D, 1, 0, 32'h0);
    add(T_NSEQ, 0, 3'd2, 3'd0, 32'h400, 32'h0,        1, 0, 32'h0);
    add(T_NSEQ, 0, 3'd1, 3'd0, 32'h41,  32'h0,        1, 0, 32'h0);
    add(T_NSEQ, 0, 3'd3, 3'd0, 32'h40,  32'h0,        1, 0, 32'h0);
    add(T_IDLE, 0, 3'd2, 3'd0, 32'h0,   32'h0,        0, 0, 32'h0);
    add(T_NSEQ, 0, 3'd2, 3'd0, 32'h08,  32'h0,        0, 0, 32'h0);
    run_queue("error");
    checks++;
    if (last_rdata === 32'hCAFEF00D) begin
      errors++;
      $display("FAIL rom_unchanged: got %08h want anything but cafef00d", last_rdata);
    end
  endtask

  task automatic test_bursts();
    sel = 1'b0; ws_cur = 0;
    add(T_NSEQ, 1, 3'd2, 3'd3, 32'h80, 32'd1, 0, 0, 32'h0);
    add(T_SEQ,  1, 3'd2, 3'd3, 32'h84, 32'd2, 0, 0, 32'h0);
    add(T_BUSY, 1, 3'd2, 3'd3, 32'h88, 32'd0, 0, 0, 32'h0);
    add(T_SEQ,  1, 3'd2, 3'd3, 32'h88, 32'd3, 0, 0, 32'h0);
    add(T_SEQ,  1, 3'd2, 3'd3, 32'h8C, 32'd4, 0, 0, 32'h0);
    add(T_NSEQ, 0, 3'd2, 3'd2, 32'h88, 32'd0, 0, 1, 32'd3);
    add(T_SEQ,  0, 3'd2, 3'd2, 32'h8C, 32'd0, 0, 1, 32'd4);
    add(T_SEQ,  0, 3'd2, 3'd2, 32'h80, 32'd0, 0, 1, 32'd1);
    add(T_SEQ,  0, 3'd2, 3'd2, 32'h84, 32'd0, 0, 1, 32'd2);
    add(T_NSEQ, 0, 3'd2, 3'd1, 32'h80, 32'd0, 0, 1, 32'd1);
    add(T_SEQ,  0, 3'd2, 3'd1, 32'h84, 32'd0, 0, 1, 32'd2);
    add(T_SEQ,  0, 3'd2, 3'd1, 32'h88, 32'd0, 0, 1, 32'd3);
    add(T_SEQ,  0, 3'd2, 3'd1, 32'h90, 32'd0, 1, 0, 32'h0);
    add(T_IDLE, 0, 3'd2, 3'd0, 32'h0,  32'd0, 0, 0, 32'h0);
    run_queue("burst");
  endtask

  task automatic test_reset_during_wait();
    sel = 1'b1; ws_cur = 2;
    add(T_NSEQ, 1, 3'd2, 3'd0, 32'h40, 32'hDEADBEEF, 0, 0, 32'h0);
    add(T_NSEQ, 0, 3'd2, 3'd0, 32'h40, 32'h0,        0, 1, 32'hDEADBEEF);
    run_queue("rstwait_pre");
    m_hsel = 1'b1; m_htrans = T_NSEQ; m_hwrite = 1'b0; m_haddr = 32'h44;
    m_hsize = 3'd2; m_hburst = 3'd0;
    @(posedge HCLK);
    #1;
    drive_idle();
    @(negedge HCLK);
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL rstwait in_wait: got ready=%0b want 0", s_ready); end
    checks++; if (s_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rstwait held_rdata: got %08h want deadbeef", s_rdata); end
    #2;
    HRESETn = 1'b0;
    #1;
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL rstwait hready: got %0b want 1", s_ready); end
    checks++; if (s_resp !== 1'b0) begin errors++; $display("FAIL rstwait hresp: got %0b want 0", s_resp); end
    checks++; if (s_rdata !== 32'h0) begin errors++; $display("FAIL rstwait hrdata: got %08h want 0", s_rdata); end
    @(posedge HCLK);
    @(negedge HCLK);
    HRESETn = 1'b1;
    settle();
    add(T_SEQ,  0, 3'd2, 3'd1, 32'h40, 32'h0, 1, 0, 32'h0);
    add(T_NSEQ, 0, 3'd2, 3'd0, 32'h40, 32'h0, 0, 1, 32'hDEADBEEF);
    run_queue("rstwait_post");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wait_states();
    test_forwarding();
    test_errors();
    test_bursts();
    test_reset_during_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before 200000");
    $fatal(1, "simulation time limit reached");
  end
endmodule
